dds_addr_gen: RTL and testbench

Tick-driven phase-accumulator address generator for the sine lookup ROM; it replaces the free-running tick/offset pair that feeds the ROM address. The frequency word from the switches is synchronised, then latched glitch-free on the sample tick. The accumulator advances once per tick, and the block presents a ROM address with a one-cycle valid strobe to the DAC/PWM stage. Overrun is flagged when the downstream serializer is still busy at a sample tick.

---
 rtl/dds_addr_gen_if.sv | 18 +
 rtl/dds_addr_gen.sv | 84 ++++++++
 tb/tb_dds_addr_gen.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dds_addr_gen_if.sv
// DAC-side handshake for dds_addr_gen: ROM address, valid strobe and busy back-pressure.
// With QUADRATURE_EN defined, the bundle also carries the 90-degree address addr_q.
interface dds_addr_gen_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              dac_busy;
`ifdef QUADRATURE_EN
  logic [ADDR_W-1:0] addr_q;

  modport master (output addr, output addr_valid, output addr_q, input dac_busy);
  modport slave  (input addr, input addr_valid, input addr_q, output dac_busy);
`else
  modport master (output addr, output addr_valid, input dac_busy);
  modport slave  (input addr, input addr_valid, output dac_busy);
`endif
endinterface

// File: rtl/dds_addr_gen.sv
// Tick-driven phase accumulator that produces sine-ROM addresses with a one-cycle valid strobe.
// Optional QUADRATURE_EN adds addr_q, which is addr offset by a quarter turn.
module dds_addr_gen #(
  parameter int TICK_DIV = 5000,
  parameter int ACC_W    = 10,
  parameter int FW_W     = 10,
  parameter int ADDR_W   = 10
) (
  input  logic            CLOCK_50,
  input  logic            RESET_N,
  input  logic [FW_W-1:0] freq_word,
  input  logic            clr_ovr,
  output logic            tick,
  output logic            overrun,
  dds_addr_gen_if.master  dac
);
  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  tick_cnt;
  logic [FW_W-1:0]   sw_meta;
  logic [FW_W-1:0]   sw_sync;
  logic [FW_W-1:0]   fw_reg;
  logic [ACC_W-1:0]  acc;
  logic              cnt_last;

  assign cnt_last = (tick_cnt == CNT_LAST);

  // ACC always coincides with tick=1; a wrap during OUT still enters ACC, so TICK_DIV=2 never drops a tick.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= IDLE;
      tick_cnt       <= '0;
      sw_meta        <= '0;
      sw_sync        <= '0;
      fw_reg         <= '0;
      acc            <= '0;
      tick           <= 1'b0;
      overrun        <= 1'b0;
      dac.addr       <= '0;
      dac.addr_valid <= 1'b0;
`ifdef QUADRATURE_EN
      dac.addr_q     <= '0;
`endif
    end else begin
      sw_meta        <= freq_word;
      sw_sync        <= sw_meta;
      tick_cnt       <= cnt_last ? '0 : tick_cnt + 1'b1;
      tick           <= cnt_last;
      dac.addr_valid <= 1'b0;

      case (state)
        ACC: begin
          fw_reg <= sw_sync;
          acc    <= acc + ACC_W'(fw_reg);
        end
        OUT: begin
          dac.addr       <= acc[ACC_W-1 -: ADDR_W];
          dac.addr_valid <= ~dac.dac_busy;
`ifdef QUADRATURE_EN
          dac.addr_q     <= acc[ACC_W-1 -: ADDR_W] + (ADDR_W'(1) << (ADDR_W - 2));
`endif
        end
        default: ;
      endcase

      if (cnt_last)
        state <= ACC;
      else if (state == ACC)
        state <= OUT;
      else
        state <= IDLE;

      // A drop in the same cycle as a clear must leave the flag set.
      if (state == OUT && dac.dac_busy)
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dds_addr_gen.sv
// Scoreboard bench for dds_addr_gen: per-sample phase model feeds a queue, a monitor checks strobes.
module tb_dds_addr_gen;
  localparam int TICK_DIV = 8;
  localparam int ACC_W    = 10;
  localparam int FW_W     = 10;
  localparam int ADDR_W   = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [FW_W-1:0] freq_word = '0;
  logic            clr_ovr = 1'b0;
  logic            tick;
  logic            overrun;

  dds_addr_gen_if #(.ADDR_W(ADDR_W)) dac ();

  dds_addr_gen #(
    .TICK_DIV(TICK_DIV),
    .ACC_W   (ACC_W),
    .FW_W    (FW_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .freq_word(freq_word),
    .clr_ovr  (clr_ovr),
    .tick     (tick),
    .overrun  (overrun),
    .dac      (dac)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: phase value, latched word, sticky flag.
  longint unsigned   acc_m = 0;
  longint unsigned   fw_reg_m = 0;
  bit                ovr_m = 0;
  int unsigned       last_tick = 0;
  logic [ADDR_W-1:0] exp_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected address.
  always @(negedge clk) begin
    if (rst_n && dac.addr_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        logic [ADDR_W-1:0] e;
        e = exp_q.pop_front();
        chk("addr", dac.addr, e);
`ifdef QUADRATURE_EN
        chk("addr_q", dac.addr_q, (int'(e) + (1 << (ADDR_W - 2))) % (1 << ADDR_W));
`endif
      end
    end
  end

  task automatic do_reset(input int fw);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tick", tick, 0);
    chk("rst_addr", dac.addr, 0);
    chk("rst_valid", dac.addr_valid, 0);
    chk("rst_overrun", overrun, 0);
    freq_word = fw;
    dac.dac_busy = 1'b0;
    clr_ovr = 1'b0;
    exp_q.delete();
    acc_m = 0;
    fw_reg_m = 0;
    ovr_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    last_tick = cyc;
  endtask

  task automatic do_sample(input int fw_next, input bit busy, input bit clr);
    bit got = 0;
    logic [ADDR_W-1:0] exp_a;
    for (int n = 0; n < 4 * TICK_DIV; n++) begin
      @(negedge clk);
      if (tick) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk("tick_timeout", 0, 1);
      return;
    end
    chk("tick_period", cyc - last_tick, TICK_DIV);
    last_tick = cyc;
    acc_m    = (acc_m + fw_reg_m) % (64'd1 << ACC_W);
    fw_reg_m = freq_word;
    exp_a    = ADDR_W'(acc_m >> (ACC_W - ADDR_W));
    if (!busy) exp_q.push_back(exp_a);
    dac.dac_busy = busy;
    @(negedge clk);
    chk("tick_width", tick, 0);
    clr_ovr = clr;
    @(negedge clk);
    ovr_m = busy ? 1'b1 : (clr ? 1'b0 : ovr_m);
    chk("overrun", overrun, ovr_m);
    chk("addr_reg", dac.addr, exp_a);
    clr_ovr = 1'b0;
    dac.dac_busy = 1'b0;
    @(negedge clk);
    chk("strobe_seen", exp_q.size(), 0);
    // Bounce the switches before settling on the next word.
    @(negedge clk);
    freq_word = FW_W'($urandom);
    @(negedge clk);
    freq_word = FW_W'($urandom);
    freq_word = FW_W'(fw_next);
  endtask

  initial begin
    dac.dac_busy = 1'b0;

    // Step of 1: 0,1,2,3 after the latch tick.
    do_reset(1);
    repeat (5) do_sample(1, 0, 0);

    // Word 1023 wraps: 0,1023,1022,1021.
    do_reset(1023);
    repeat (5) do_sample(1023, 0, 0);

    // Word change 1 -> 4 mid-period.
    do_reset(1);
    do_sample(1, 0, 0);
    do_sample(4, 0, 0);
    repeat (4) do_sample(4, 0, 0);

    // Dropped sample, held flag, set-wins-over-clear, then plain clear.
    do_sample(4, 1, 0);
    do_sample(4, 0, 0);
    do_sample(4, 1, 1);
    do_sample(4, 0, 1);
    do_sample(4, 0, 0);

    // Randomized run with a mid-run reset.
    for (int i = 0; i < 60; i++) begin
      if (i == 30) do_reset(int'($urandom % (1 << FW_W)));
      do_sample(int'($urandom % (1 << FW_W)), ($urandom % 4) == 0, ($urandom % 3) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    chk("final_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
